// File: rtl/pe_array_feeder.sv
// Skewing operand feeder and sequencer for an N x N MAC array: buffers A/B,
// streams them diagonally into the array edges, drains, then exposes results.

module pe_feeder_lane #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int CW     = 4,
    parameter int LANE   = 0
) (
    input  logic                       en,
    input  logic [CW-1:0]              step,
    input  logic [N-1:0][DATA_W-1:0]   vec,
    output logic [DATA_W-1:0]          val
);
    // Lane LANE sees element k of its vector at step LANE+k; zero outside the window.
    always_comb begin
        val = '0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                if (step == CW'(LANE + k)) val = vec[k];
            end
        end
    end
endmodule

module pe_array_feeder #(
    parameter int N        = 4,
    parameter int DATA_W   = 8,
    parameter int MULT_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   wr_mat,
    input  logic [$clog2(N)-1:0]   wr_row,
    input  logic [$clog2(N)-1:0]   wr_col,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   start,
    input  logic                   rd_ack,
    output logic [N*DATA_W-1:0]    a_out,
    output logic [N*DATA_W-1:0]    b_out,
    output logic                   acc_clr,
    output logic                   pe_sel,
    output logic                   busy,
    output logic                   done
);
    localparam int CW          = $clog2(3*N + MULT_LAT + 1);
    localparam int STREAM_LAST = 2*N - 2;
    localparam int DRAIN_LAST  = N + MULT_LAT - 1;

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, READ} state_t;

    state_t  state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic [N-1:0][N-1:0][DATA_W-1:0] abuf, bbuf;
    logic [N-1:0][N-1:0][DATA_W-1:0] bcol;
    logic [N-1:0][DATA_W-1:0]        a_lane, b_lane;
    logic                            stream_n;

    // Buffers are deliberately left out of reset so a reset does not lose operands.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE) begin
            if (wr_mat) bbuf[wr_row][wr_col] <= wr_data;
            else        abuf[wr_row][wr_col] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE:   if (start) state_n = CLEAR;
            CLEAR: begin
                state_n = STREAM;
                cnt_n   = '0;
            end
            STREAM: begin
                if (cnt == CW'(STREAM_LAST)) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DRAIN: begin
                if (cnt == CW'(DRAIN_LAST)) begin
                    state_n = READ;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            READ:   if (rd_ack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Lane values are computed from the next state so every output can be registered.
    assign stream_n = (state_n == STREAM);

    for (genvar g = 0; g < N; g++) begin : g_lane
        for (genvar k = 0; k < N; k++) begin : g_col
            assign bcol[g][k] = bbuf[k][g];
        end
        pe_feeder_lane #(.N(N), .DATA_W(DATA_W), .CW(CW), .LANE(g)) u_a (
            .en(stream_n), .step(cnt_n), .vec(abuf[g]), .val(a_lane[g])
        );
        pe_feeder_lane #(.N(N), .DATA_W(DATA_W), .CW(CW), .LANE(g)) u_b (
            .en(stream_n), .step(cnt_n), .vec(bcol[g]), .val(b_lane[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out   <= '0;
            b_out   <= '0;
            acc_clr <= 1'b0;
            pe_sel  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            a_out   <= a_lane;
            b_out   <= b_lane;
            acc_clr <= (state_n == CLEAR);
            pe_sel  <= (state_n == READ);
            busy    <= (state_n != IDLE);
            done    <= (state_n == READ) && (state != READ);
        end
    end
endmodule
